// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller for the frog/croc game.
// Tracks lives, level and score, sequences IDLE/PLAY/DYING/CLEAR/OVER and
// drives the frog reset pulse, croc enable and per-lane croc speeds.
module game_sequencer #(
  parameter int LIVES_INIT = 3,
  parameter int GOAL_X     = 600,
  parameter int HOLD_TICKS = 60,
  parameter int MAX_LEVEL  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       die,
  input  logic [9:0] frog_x,
  output logic [2:0] state,
  output logic       frog_rst,
  output logic       croc_en,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic [7:0] score,
  output logic [2:0] speed1,
  output logic [2:0] speed2,
  output logic [2:0] speed3
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     cur_state, nxt_state;
  logic       start_d;
  logic       start_edge;
  logic [6:0] hold_cnt, hold_nxt, hold_inc;
  logic       hold_done;
  logic [1:0] lives_nxt, level_nxt;
  logic [7:0] score_nxt;

  assign start_edge = start & ~start_d;
  assign hold_inc   = hold_cnt + 7'd1;
  assign hold_done  = tick && (hold_inc == 7'(HOLD_TICKS));
  assign state      = cur_state;

  // Start-button history; it keeps following start during reset so a
  // button held through reset is not seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    start_d <= start;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_IDLE;
    else     cur_state <= nxt_state;
  end

  // Next-state logic plus next values of the game counters.
  always_comb begin
    nxt_state = cur_state;
    hold_nxt  = hold_cnt;
    lives_nxt = lives;
    level_nxt = level;
    score_nxt = score;
    case (cur_state)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          nxt_state = S_PLAY;
          lives_nxt = 2'(LIVES_INIT);
          level_nxt = 2'd0;
          score_nxt = 8'd0;
        end
      end
      S_PLAY: begin
        // A death in the same frame as reaching the goal counts as a death.
        if (die) begin
          nxt_state = S_DYING;
          lives_nxt = lives - 2'd1;
          hold_nxt  = 7'd0;
        end else if (frog_x >= 10'(GOAL_X)) begin
          nxt_state = S_CLEAR;
          score_nxt = (score == 8'hFF) ? score : score + 8'd1;
          hold_nxt  = 7'd0;
        end
      end
      S_DYING: begin
        if (tick) hold_nxt = hold_inc;
        if (hold_done) nxt_state = (lives == 2'd0) ? S_OVER : S_PLAY;
      end
      S_CLEAR: begin
        if (tick) hold_nxt = hold_inc;
        if (hold_done) begin
          nxt_state = S_PLAY;
          level_nxt = (level >= 2'(MAX_LEVEL)) ? 2'(MAX_LEVEL) : level + 2'd1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Game counters and registered play-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 7'd0;
      lives    <= 2'(LIVES_INIT);
      level    <= 2'd0;
      score    <= 8'd0;
      frog_rst <= 1'b0;
      croc_en  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      lives    <= lives_nxt;
      level    <= level_nxt;
      score    <= score_nxt;
      frog_rst <= (nxt_state == S_PLAY) && (cur_state != S_PLAY);
      croc_en  <= (nxt_state == S_PLAY);
    end
  end

  // Croc lane speeds grow with level; level tops out at 3, so 6 is the max.
  assign speed1 = 3'd1 + {1'b0, level};
  assign speed2 = 3'd2 + {1'b0, level};
  assign speed3 = 3'd3 + {1'b0, level};

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a vector table walks a full game, then
// hand-written sequences cover level saturation and reset during a hold.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       die = 1'b0;
  logic [9:0] frog_x = 10'd0;
  logic [2:0] state;
  logic       frog_rst, croc_en;
  logic [1:0] lives, level;
  logic [7:0] score;
  logic [2:0] speed1, speed2, speed3;

  int total = 0;
  int bad   = 0;

  game_sequencer #(
    .LIVES_INIT(3), .GOAL_X(600), .HOLD_TICKS(4), .MAX_LEVEL(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .die(die),
    .frog_x(frog_x), .state(state), .frog_rst(frog_rst), .croc_en(croc_en),
    .lives(lives), .level(level), .score(score),
    .speed1(speed1), .speed2(speed2), .speed3(speed3)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       r, t, s, d;
    int       fx;
    int       st, li, lv, sc, fr, ce;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, t, s, d, input int fx,
                     input int st, li, lv, sc, fr, ce);
    vec_t v;
    v.r = r; v.t = t; v.s = s; v.d = d; v.fx = fx;
    v.st = st; v.li = li; v.lv = lv; v.sc = sc; v.fr = fr; v.ce = ce;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input bit r, t, s, d, input int fx);
    @(negedge clk);
    rst = r; tick = t; start = s; die = d; frog_x = 10'(fx);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int st, li, lv, sc, fr, ce);
    check({tag, ".state"},    int'(state),    st);
    check({tag, ".lives"},    int'(lives),    li);
    check({tag, ".level"},    int'(level),    lv);
    check({tag, ".score"},    int'(score),    sc);
    check({tag, ".frog_rst"}, int'(frog_rst), fr);
    check({tag, ".croc_en"},  int'(croc_en),  ce);
  endtask

  initial begin
    //   r t s d fx     st li lv sc fr ce
    add(1,0,0,0,0,      0, 3, 0, 0, 0, 0); // reset
    add(0,0,0,1,700,    0, 3, 0, 0, 0, 0); // die/frog_x ignored in IDLE
    add(0,0,1,0,0,      1, 3, 0, 0, 1, 1); // start edge
    add(0,0,1,0,0,      1, 3, 0, 0, 0, 1); // held start, no retrigger
    add(0,0,0,0,0,      1, 3, 0, 0, 0, 1);
    add(0,0,0,1,0,      2, 2, 0, 0, 0, 0); // die
    add(0,1,0,0,0,      2, 2, 0, 0, 0, 0); // tick 1
    add(0,0,0,0,0,      2, 2, 0, 0, 0, 0); // no tick, no advance
    add(0,1,0,0,0,      2, 2, 0, 0, 0, 0); // tick 2
    add(0,0,0,1,0,      2, 2, 0, 0, 0, 0); // die ignored in DYING
    add(0,1,0,0,0,      2, 2, 0, 0, 0, 0); // tick 3
    add(0,1,0,0,0,      1, 2, 0, 0, 1, 1); // tick 4 -> PLAY
    add(0,0,0,0,0,      1, 2, 0, 0, 0, 1);
    add(0,0,0,1,650,    2, 1, 0, 0, 0, 0); // die beats goal
    add(0,1,0,0,0,      2, 1, 0, 0, 0, 0);
    add(0,1,0,0,0,      2, 1, 0, 0, 0, 0);
    add(0,1,0,0,0,      2, 1, 0, 0, 0, 0);
    add(0,1,0,0,0,      1, 1, 0, 0, 1, 1);
    add(0,0,0,0,600,    3, 1, 0, 1, 0, 0); // goal exactly at 600
    add(0,1,0,1,0,      3, 1, 0, 1, 0, 0); // die ignored in CLEAR
    add(0,1,0,0,0,      3, 1, 0, 1, 0, 0);
    add(0,1,0,0,0,      3, 1, 0, 1, 0, 0);
    add(0,1,0,0,0,      1, 1, 1, 1, 1, 1); // level up
    add(0,0,0,1,0,      2, 0, 1, 1, 0, 0); // third death
    add(0,1,0,0,0,      2, 0, 1, 1, 0, 0);
    add(0,1,0,0,0,      2, 0, 1, 1, 0, 0);
    add(0,1,0,0,0,      2, 0, 1, 1, 0, 0);
    add(0,1,0,0,0,      4, 0, 1, 1, 0, 0); // game over
    add(0,0,0,1,600,    4, 0, 1, 1, 0, 0); // inputs ignored in OVER
    add(0,0,1,0,0,      1, 3, 0, 0, 1, 1); // restart from OVER
    add(0,0,0,0,0,      1, 3, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].d, vecs[i].fx);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].li, vecs[i].lv,
                vecs[i].sc, vecs[i].fr, vecs[i].ce);
      check($sformatf("vec%0d.speed1", i), int'(speed1), vecs[i].lv + 1);
      check($sformatf("vec%0d.speed2", i), int'(speed2), vecs[i].lv + 2);
      check($sformatf("vec%0d.speed3", i), int'(speed3), vecs[i].lv + 3);
    end

    // Four clears in a row: level saturates at 3, score keeps counting.
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 600);
      check($sformatf("clr%0d.state", c), int'(state), 3);
      check($sformatf("clr%0d.score", c), int'(score), c + 1);
      for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
      check($sformatf("clr%0d.exit", c), int'(state), 1);
      check($sformatf("clr%0d.level", c), int'(level), (c < 3) ? c + 1 : 3);
    end
    check("sat.speed1", int'(speed1), 4);
    check("sat.speed2", int'(speed2), 5);
    check("sat.speed3", int'(speed3), 6);

    // Reset in the middle of a DYING hold with start held high.
    step(0, 0, 0, 1, 0);
    check("mid.state", int'(state), 2);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 700);
    check_all("rst_mid", 0, 3, 0, 0, 0, 0);
    check("rst_mid.speed3", int'(speed3), 3);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("held%0d.state", k), int'(state), 0);
      check($sformatf("held%0d.croc_en", k), int'(croc_en), 0);
    end
    step(0, 0, 0, 0, 0);
    check("release.state", int'(state), 0);
    step(0, 0, 1, 0, 0);
    check_all("repress", 1, 3, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0);
    check("repress.frog_rst_off", int'(frog_rst), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
